// File: rtl/switch_pkg.sv
// Shared defaults for the push-button debouncer: channel count and cycle counts
// for debounce and auto-repeat, plus a counter-width helper.
package switch_pkg;

   localparam int SWITCH_WIDTH          = 8;
   localparam int DEBOUNCE_CYCLES_DEF   = 1000000;
   localparam int REPEAT_DELAY_DEF      = 50000000;
   localparam int REPEAT_PERIOD_DEF     = 10000000;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and
// press/release pulses. Auto-repeat hold counter is built only with SWITCH_AUTOREPEAT_EN.
module debounce_channel
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic Clk,
   input  logic Reset,
   input  logic switch_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("debounce_channel: cycle-count parameters out of range");
   end

   logic [1:0]    sync_reg;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          pressed_reg, pressed_next;
   logic          press_pulse_reg, press_pulse_next;
   logic          release_pulse_reg, release_pulse_next;
   logic          sync, differs, accept, repeat_fire;

   assign sync    = ~sync_reg[1];
   assign differs = sync ^ pressed_reg;
   assign accept  = differs && (cnt_reg == CNT_LAST);

   always_comb begin
      cnt_next     = cnt_reg;
      pressed_next = pressed_reg;
      if (!differs) begin
         cnt_next = '0;
      end else if (accept) begin
         cnt_next     = '0;
         pressed_next = ~pressed_reg;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   assign press_pulse_next   = (accept & ~pressed_reg) | repeat_fire;
   assign release_pulse_next = accept & pressed_reg;

`ifdef SWITCH_AUTOREPEAT_EN
   localparam int HW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

   logic [HW-1:0] hold_reg, hold_next;
   logic          repeating_reg, repeating_next;

   // First repeat waits the long delay; later ones use the shorter period.
   always_comb begin
      hold_next      = hold_reg;
      repeating_next = repeating_reg;
      repeat_fire    = 1'b0;
      if (accept || !pressed_reg) begin
         hold_next      = '0;
         repeating_next = 1'b0;
      end else if (hold_reg == (repeating_reg ? PERIOD_LAST : DELAY_LAST)) begin
         repeat_fire    = 1'b1;
         hold_next      = '0;
         repeating_next = 1'b1;
      end else begin
         hold_next = hold_reg + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hold_reg      <= '0;
         repeating_reg <= 1'b0;
      end else begin
         hold_reg      <= hold_next;
         repeating_reg <= repeating_next;
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_reg          <= 2'b11;
         cnt_reg           <= '0;
         pressed_reg       <= 1'b0;
         press_pulse_reg   <= 1'b0;
         release_pulse_reg <= 1'b0;
      end else begin
         sync_reg          <= {sync_reg[0], switch_n};
         cnt_reg           <= cnt_next;
         pressed_reg       <= pressed_next;
         press_pulse_reg   <= press_pulse_next;
         release_pulse_reg <= release_pulse_next;
      end
   end

   assign pressed       = pressed_reg;
   assign press_pulse   = press_pulse_reg;
   assign release_pulse = release_pulse_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH active-low buttons and encodes the lowest pressed channel as a key event.
// Optional auto-repeat of press pulses is enabled by defining SWITCH_AUTOREPEAT_EN.
module switch_debouncer
   import switch_pkg::*;
#(
   parameter  int WIDTH           = SWITCH_WIDTH,
   parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter  int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter  int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
   localparam int INDEX_W         = cnt_width(WIDTH)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [WIDTH-1:0]   Switch,
   output logic [WIDTH-1:0]   Pressed,
   output logic [WIDTH-1:0]   PressPulse,
   output logic [WIDTH-1:0]   ReleasePulse,
   output logic               KeyValid,
   output logic [INDEX_W-1:0] KeyIndex
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_channel
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_channel (
         .Clk           (Clk),
         .Reset         (Reset),
         .switch_n      (Switch[gi]),
         .pressed       (Pressed[gi]),
         .press_pulse   (PressPulse[gi]),
         .release_pulse (ReleasePulse[gi])
      );
   end

   logic               key_valid_reg;
   logic [INDEX_W-1:0] key_index_reg, key_index_next;

   // Scan downwards so the lowest set pulse wins; index holds when no pulse.
   always_comb begin
      key_index_next = key_index_reg;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (PressPulse[i]) key_index_next = INDEX_W'(i);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         key_valid_reg <= 1'b0;
         key_index_reg <= '0;
      end else begin
         key_valid_reg <= |PressPulse;
         key_index_reg <= key_index_next;
      end
   end

   assign KeyValid = key_valid_reg;
   assign KeyIndex = key_index_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus randomized
// button activity compared against a cycle-level behavioural model.
module tb_switch_debouncer;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic [W-1:0] Switch = '1;
   logic [W-1:0] Pressed, PressPulse, ReleasePulse;
   logic         KeyValid;
   logic [2:0]   KeyIndex;

   int vectors = 0;
   int miscompares = 0;

   always #5 Clk = ~Clk;

   switch_debouncer #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Switch       (Switch),
      .Pressed      (Pressed),
      .PressPulse   (PressPulse),
      .ReleasePulse (ReleasePulse),
      .KeyValid     (KeyValid),
      .KeyIndex     (KeyIndex)
   );

   // Reference model: raw input delayed two edges, run length of disagreeing samples,
   // and age of each held button since its accepted press.
   logic [W-1:0] m_s1 = '1, m_s2 = '1, m_pressed = '0, m_press = '0, m_release = '0;
   logic         m_kv = 1'b0;
   logic [2:0]   m_ki = '0;
   int           m_run[W];
   int           m_age[W];

   task automatic model_step();
      logic [W-1:0] old_press;
      logic sync_i, toggled;
      old_press = m_press;
      if (Reset) begin
         m_s1 = '1; m_s2 = '1; m_pressed = '0; m_press = '0; m_release = '0;
         m_kv = 1'b0; m_ki = '0;
         for (int i = 0; i < W; i++) begin m_run[i] = 0; m_age[i] = 0; end
         return;
      end
      m_kv = |old_press;
      for (int i = W - 1; i >= 0; i--) if (old_press[i]) m_ki = 3'(i);
      for (int i = 0; i < W; i++) begin
         sync_i = ~m_s2[i];
         m_press[i] = 1'b0;
         m_release[i] = 1'b0;
         toggled = (sync_i != m_pressed[i]) && (m_run[i] == D - 1);
         m_run[i] = ((sync_i != m_pressed[i]) && !toggled) ? m_run[i] + 1 : 0;
         if (toggled) begin
            m_pressed[i] = ~m_pressed[i];
            if (m_pressed[i]) m_press[i] = 1'b1; else m_release[i] = 1'b1;
            m_age[i] = 0;
         end else if (m_pressed[i]) begin
            m_age[i]++;
`ifdef SWITCH_AUTOREPEAT_EN
            if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) m_press[i] = 1'b1;
`endif
         end
      end
      m_s2 = m_s1;
      m_s1 = Switch;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      #1;
   endtask

   task automatic settle();
      Switch = '1;
      repeat (D + 6) tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold: got P=%h PP=%h RP=%h KV=%b KI=%0d, want all 0",
                  Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex);
      end
      Reset = 1'b0;
      repeat (D + 4) tick();
      vectors++;
      if ({Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex} !== '0) begin
         miscompares++;
         $display("FAIL reset_idle: got P=%h PP=%h RP=%h KV=%b KI=%0d, want all 0",
                  Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex);
      end
      $display("test_reset done");
   endtask

   task automatic test_press();
      logic [W-1:0] exp;
      Switch[3] = 1'b0;
      for (int k = 1; k <= D + 2; k++) begin
         tick();
         exp = (k == D + 2) ? 8'h08 : 8'h00;
         vectors++;
         if (Pressed !== exp || PressPulse !== exp) begin
            miscompares++;
            $display("FAIL press_latency cycle %0d: got P=%h PP=%h, want %h", k, Pressed, PressPulse, exp);
         end
      end
      tick();
      vectors++;
      if (PressPulse !== 8'h00 || KeyValid !== 1'b1 || KeyIndex !== 3'd3) begin
         miscompares++;
         $display("FAIL press_key: got PP=%h KV=%b KI=%0d, want 00 1 3", PressPulse, KeyValid, KeyIndex);
      end
      tick();
      vectors++;
      if (KeyValid !== 1'b0 || KeyIndex !== 3'd3 || Pressed !== 8'h08) begin
         miscompares++;
         $display("FAIL press_hold: got KV=%b KI=%0d P=%h, want 0 3 08", KeyValid, KeyIndex, Pressed);
      end
      settle();
      $display("test_press ch3 done");
   endtask

   task automatic test_glitch();
      Switch[0] = 1'b0;
      repeat (3) tick();
      Switch[0] = 1'b1;
      for (int k = 0; k < D + 6; k++) begin
         tick();
         vectors++;
         if (Pressed !== '0 || PressPulse !== '0 || ReleasePulse !== '0) begin
            miscompares++;
            $display("FAIL glitch cycle %0d: got P=%h PP=%h RP=%h, want 00", k, Pressed, PressPulse, ReleasePulse);
         end
      end
      $display("test_glitch ch0 done");
   endtask

   task automatic test_simultaneous();
      Switch[5] = 1'b0;
      Switch[2] = 1'b0;
      repeat (D + 2) tick();
      vectors++;
      if (PressPulse !== 8'h24 || Pressed !== 8'h24) begin
         miscompares++;
         $display("FAIL simul_pulse: got PP=%h P=%h, want 24 24", PressPulse, Pressed);
      end
      tick();
      vectors++;
      if (KeyValid !== 1'b1 || KeyIndex !== 3'd2) begin
         miscompares++;
         $display("FAIL simul_key: got KV=%b KI=%0d, want 1 2", KeyValid, KeyIndex);
      end
      settle();
      $display("test_simultaneous ch5+ch2 done");
   endtask

   task automatic test_release();
      logic [W-1:0] exp_r, exp_p;
      Switch[1] = 1'b0;
      repeat (D + 3) tick();
      Switch[1] = 1'b1;
      for (int k = 1; k <= D + 2; k++) begin
         tick();
         exp_r = (k == D + 2) ? 8'h02 : 8'h00;
         exp_p = (k == D + 2) ? 8'h00 : 8'h02;
         vectors++;
         if (ReleasePulse !== exp_r || Pressed !== exp_p || PressPulse !== 8'h00) begin
            miscompares++;
            $display("FAIL release cycle %0d: got RP=%h P=%h PP=%h, want %h %h 00",
                     k, ReleasePulse, Pressed, PressPulse, exp_r, exp_p);
         end
      end
      tick();
      vectors++;
      if (ReleasePulse !== 8'h00) begin
         miscompares++;
         $display("FAIL release_width: got RP=%h, want 00", ReleasePulse);
      end
      settle();
      $display("test_release ch1 done");
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] exp;
      Switch[4] = 1'b0;
      repeat (4) tick();
      Reset = 1'b1;
      tick();
      vectors++;
      if ({Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: got P=%h PP=%h RP=%h KV=%b KI=%0d, want all 0",
                  Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex);
      end
      tick();
      Reset = 1'b0;
      for (int k = 1; k <= D + 2; k++) begin
         tick();
         exp = (k == D + 2) ? 8'h10 : 8'h00;
         vectors++;
         if (Pressed !== exp || PressPulse !== exp) begin
            miscompares++;
            $display("FAIL reset_reaccept cycle %0d: got P=%h PP=%h, want %h", k, Pressed, PressPulse, exp);
         end
      end
      settle();
      $display("test_reset_mid ch4 done");
   endtask

`ifdef SWITCH_AUTOREPEAT_EN
   task automatic test_autorepeat();
      logic exp_pp, exp_rp, exp_p;
      Switch[7] = 1'b0;
      repeat (D + 2) tick();
      vectors++;
      if (PressPulse !== 8'h80) begin
         miscompares++;
         $display("FAIL repeat_accept: got PP=%h, want 80", PressPulse);
      end
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (k == 16) Switch[7] = 1'b1;
         exp_pp = (k >= RD) && (k < 16 + D + 2) && ((k - RD) % RP == 0);
         exp_rp = (k == 16 + D + 2);
         exp_p  = (k < 16 + D + 2);
         vectors++;
         if (PressPulse[7] !== exp_pp || ReleasePulse[7] !== exp_rp || Pressed[7] !== exp_p) begin
            miscompares++;
            $display("FAIL repeat cycle %0d: got PP=%b RP=%b P=%b, want %b %b %b",
                     k, PressPulse[7], ReleasePulse[7], Pressed[7], exp_pp, exp_rp, exp_p);
         end
      end
      settle();
      $display("test_autorepeat ch7 done");
   endtask
`endif

   task automatic test_random();
      int errs;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 5) == 0) Switch[i] = ~Switch[i];
         end
         Reset = ($urandom_range(0, 249) == 0);
         tick();
         vectors++;
         if ({Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex} !==
             {m_pressed, m_press, m_release, m_kv, m_ki}) begin
            miscompares++;
            errs++;
            $display("FAIL random cycle %0d: got P=%h PP=%h RP=%h KV=%b KI=%0d, want P=%h PP=%h RP=%h KV=%b KI=%0d",
                     c, Pressed, PressPulse, ReleasePulse, KeyValid, KeyIndex,
                     m_pressed, m_press, m_release, m_kv, m_ki);
         end
         if (c % 100 == 99) $display("test_random cycles %0d..%0d, %0d errors so far", c - 99, c, errs);
      end
      Reset = 1'b0;
      settle();
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_simultaneous();
      test_release();
      test_reset_mid();
`ifdef SWITCH_AUTOREPEAT_EN
      test_autorepeat();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
